// File: rtl/sys_defs.sv
// Shared definitions for the data-memory port arbiter: bus encodings,
// access sizes, arbiter states and the latched load packet.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int MEM_TAG_W   = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    ST_ISSUE,
    LD_ISSUE,
    LD_WAIT,
    LD_DRAIN
  } ARB_STATE;

  typedef struct packed {
    logic [XLEN-1:0]        address;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [MEM_TAG_W-1:0]   mem_tag;
  } ARB_LD_PACKET;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Processor <-> data-memory bus. The arbiter is the master (issues
// commands); the memory model/controller is the slave (responds).
interface mem_port_arbiter_if;
  import sys_defs::*;

  BUS_COMMAND             proc2mem_command;
  logic [XLEN-1:0]        proc2mem_addr;
  logic [XLEN-1:0]        proc2mem_data;
  MEM_SIZE                proc2mem_size;
  logic [MEM_TAG_W-1:0]   mem2proc_response;
  logic [XLEN-1:0]        mem2proc_data;
  logic [MEM_TAG_W-1:0]   mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );

endinterface

// File: rtl/mem_arb_perf_counters.sv
// Saturating event counters for the memory port arbiter.
// Present only when MEM_ARB_PERF_EN is defined.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf_counters
  import sys_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        inc_load,
  input  logic        inc_store,
  input  logic        inc_stall,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall_cycles
);

  // Count accepted loads, accepted stores and refused issue cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (inc_load)  perf_loads        <= sat_inc(perf_loads);
      if (inc_store) perf_stores       <= sat_inc(perf_stores);
      if (inc_stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the load buffer and the
// ROB store-commit path. Committed stores win; one transaction is
// outstanding at a time; flushed loads are drained until their tag
// returns. Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
  import sys_defs::*;
(
  input  logic                   clock,
  input  logic                   reset,
  mem_port_arbiter_if.master     mem,
  input  logic                   read_mem,
  input  logic [XLEN-1:0]        load_address,
  input  logic [ROB_TAG_LEN-1:0] load_rob_tag,
  input  logic                   st_req,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [XLEN-1:0]        st_data,
  input  logic [1:0]             st_size,
  input  logic                   flush,
  output logic                   mem_busy,
  output logic                   st_done,
  output logic                   ld_done_valid,
  output logic [XLEN-1:0]        ld_done_data,
  output logic [ROB_TAG_LEN-1:0] ld_done_rob_tag
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_loads,
  output logic [31:0]            perf_stores,
  output logic [31:0]            perf_stall_cycles
`endif
);

  ARB_STATE               state, state_nxt;
  ARB_LD_PACKET           ld_pkt, ld_pkt_nxt;
  logic [XLEN-1:0]        st_addr_q, st_addr_nxt;
  logic [XLEN-1:0]        st_data_q, st_data_nxt;
  MEM_SIZE                st_size_q, st_size_nxt;
  logic                   ld_done_valid_nxt;
  logic [XLEN-1:0]        ld_done_data_nxt;
  logic [ROB_TAG_LEN-1:0] ld_done_rob_tag_nxt;
  logic                   accepted;
  logic                   tag_match;

  assign accepted  = (mem.mem2proc_response != '0);
  // Tag 0 means "no data this cycle", so it can never complete a load.
  assign tag_match = (mem.mem2proc_tag == ld_pkt.mem_tag) && (mem.mem2proc_tag != '0);
  // A pending store request already owns the next cycle of the port.
  assign mem_busy  = (state != IDLE) || st_req;

  // State and latched transaction fields; reset abandons any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ld_pkt          <= '0;
      st_addr_q       <= '0;
      st_data_q       <= '0;
      st_size_q       <= BYTE;
      ld_done_valid   <= 1'b0;
      ld_done_data    <= '0;
      ld_done_rob_tag <= '0;
    end else begin
      state           <= state_nxt;
      ld_pkt          <= ld_pkt_nxt;
      st_addr_q       <= st_addr_nxt;
      st_data_q       <= st_data_nxt;
      st_size_q       <= st_size_nxt;
      ld_done_valid   <= ld_done_valid_nxt;
      ld_done_data    <= ld_done_data_nxt;
      ld_done_rob_tag <= ld_done_rob_tag_nxt;
    end
  end

  // Next-state, bus drive and completion decode for each arbiter state.
  always_comb begin
    state_nxt             = state;
    ld_pkt_nxt            = ld_pkt;
    st_addr_nxt           = st_addr_q;
    st_data_nxt           = st_data_q;
    st_size_nxt           = st_size_q;
    ld_done_valid_nxt     = 1'b0;
    ld_done_data_nxt      = ld_done_data;
    ld_done_rob_tag_nxt   = ld_done_rob_tag;
    st_done               = 1'b0;
    mem.proc2mem_command  = BUS_NONE;
    mem.proc2mem_addr     = '0;
    mem.proc2mem_data     = '0;
    mem.proc2mem_size     = BYTE;

    case (state)
      IDLE: begin
        if (st_req) begin
          st_addr_nxt = st_addr;
          st_data_nxt = st_data;
          st_size_nxt = MEM_SIZE'(st_size);
          state_nxt   = ST_ISSUE;
        end else if (read_mem) begin
          ld_pkt_nxt.address = load_address;
          ld_pkt_nxt.rob_tag = load_rob_tag;
          ld_pkt_nxt.mem_tag = '0;
          state_nxt          = LD_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Stores are already committed, so flush is deliberately ignored.
        mem.proc2mem_command = BUS_STORE;
        mem.proc2mem_addr    = st_addr_q;
        mem.proc2mem_data    = st_data_q;
        mem.proc2mem_size    = st_size_q;
        if (accepted) begin
          st_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      LD_ISSUE: begin
        // Suppressing the command on flush keeps memory from ever
        // accepting a load that nobody will wait for.
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          mem.proc2mem_command = BUS_LOAD;
          mem.proc2mem_addr    = ld_pkt.address;
          mem.proc2mem_size    = WORD;
          if (accepted) begin
            ld_pkt_nxt.mem_tag = mem.mem2proc_response;
            state_nxt          = LD_WAIT;
          end
        end
      end
      LD_WAIT: begin
        if (tag_match) begin
          state_nxt = IDLE;
          if (!flush) begin
            ld_done_valid_nxt   = 1'b1;
            ld_done_data_nxt    = mem.mem2proc_data;
            ld_done_rob_tag_nxt = ld_pkt.rob_tag;
          end
        end else if (flush) begin
          state_nxt = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (tag_match) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_counters u_perf (
    .clock             (clock),
    .reset             (reset),
    .inc_load          ((state == LD_ISSUE) && !flush && accepted),
    .inc_store         (st_done),
    .inc_stall         (((state == ST_ISSUE) || (state == LD_ISSUE)) && !accepted),
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level expectation.
module tb_mem_port_arbiter;
  import sys_defs::*;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   read_mem;
  logic [XLEN-1:0]        load_address;
  logic [ROB_TAG_LEN-1:0] load_rob_tag;
  logic                   st_req;
  logic [XLEN-1:0]        st_addr;
  logic [XLEN-1:0]        st_data;
  logic [1:0]             st_size;
  logic                   flush;
  logic                   mem_busy;
  logic                   st_done;
  logic                   ld_done_valid;
  logic [XLEN-1:0]        ld_done_data;
  logic [ROB_TAG_LEN-1:0] ld_done_rob_tag;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]            perf_loads, perf_stores, perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if mem_if ();

  mem_port_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .mem             (mem_if.master),
    .read_mem        (read_mem),
    .load_address    (load_address),
    .load_rob_tag    (load_rob_tag),
    .st_req          (st_req),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_size         (st_size),
    .flush           (flush),
    .mem_busy        (mem_busy),
    .st_done         (st_done),
    .ld_done_valid   (ld_done_valid),
    .ld_done_data    (ld_done_data),
    .ld_done_rob_tag (ld_done_rob_tag)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_loads        (perf_loads),
    .perf_stores       (perf_stores),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    read_mem = 1'b0; load_address = '0; load_rob_tag = '0;
    st_req = 1'b0; st_addr = '0; st_data = '0; st_size = '0; flush = 1'b0;
    mem_if.mem2proc_response = '0; mem_if.mem2proc_data = '0; mem_if.mem2proc_tag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clock); #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL rst_cmd got %0d exp %0d", mem_if.proc2mem_command, BUS_NONE); end
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", mem_busy); end
    checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", ld_done_valid); end
    checks++; if (st_done !== 1'b0) begin errors++; $display("FAIL rst_st_done got %0b exp 0", st_done); end
    checks++; if (ld_done_data !== '0 || ld_done_rob_tag !== '0) begin errors++; $display("FAIL rst_ld_fields got %h/%0d exp 0/0", ld_done_data, ld_done_rob_tag); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_load_basic();
    @(negedge clock); read_mem = 1'b1; load_address = 32'h10; load_rob_tag = 5'd2; #1;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL ld_t0_busy got %0b exp 0", mem_busy); end
    @(negedge clock); read_mem = 1'b0; load_address = '0; mem_if.mem2proc_response = 4'd3; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_LOAD) begin errors++; $display("FAIL ld_cmd got %0d exp %0d", mem_if.proc2mem_command, BUS_LOAD); end
    checks++; if (mem_if.proc2mem_addr !== 32'h10) begin errors++; $display("FAIL ld_addr got %h exp 10", mem_if.proc2mem_addr); end
    checks++; if (mem_if.proc2mem_size !== WORD) begin errors++; $display("FAIL ld_size got %0d exp %0d", mem_if.proc2mem_size, WORD); end
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL ld_t1_busy got %0b exp 1", mem_busy); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      mem_if.mem2proc_response = '0;
      mem_if.mem2proc_tag  = (k == 4) ? 4'd3 : 4'd0;
      mem_if.mem2proc_data = (k == 4) ? 32'hDEAD : 32'h0;
      #1;
      checks++; if (mem_busy !== 1'b1 || mem_if.proc2mem_command !== BUS_NONE || ld_done_valid !== 1'b0) begin
        errors++; $display("FAIL ld_wait_t%0d busy/cmd/valid got %0b/%0d/%0b exp 1/0/0", k, mem_busy, mem_if.proc2mem_command, ld_done_valid); end
    end
    @(negedge clock); mem_if.mem2proc_tag = '0; mem_if.mem2proc_data = '0; #1;
    checks++; if (ld_done_valid !== 1'b1) begin errors++; $display("FAIL ld_done_valid got %0b exp 1", ld_done_valid); end
    checks++; if (ld_done_data !== 32'hDEAD) begin errors++; $display("FAIL ld_done_data got %h exp dead", ld_done_data); end
    checks++; if (ld_done_rob_tag !== 5'd2) begin errors++; $display("FAIL ld_done_rob got %0d exp 2", ld_done_rob_tag); end
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL ld_t5_busy got %0b exp 0", mem_busy); end
    @(negedge clock); #1;
    checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("FAIL ld_valid_pulse got %0b exp 0", ld_done_valid); end
  endtask

  task automatic test_store_retry();
    @(negedge clock); st_req = 1'b1; st_addr = 32'h20; st_data = 32'h55; st_size = 2'd2; #1;
    checks++; if (mem_busy !== 1'b1 || mem_if.proc2mem_command !== BUS_NONE) begin
      errors++; $display("FAIL st_t0 busy/cmd got %0b/%0d exp 1/0", mem_busy, mem_if.proc2mem_command); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock); mem_if.mem2proc_response = (k == 3) ? 4'd1 : 4'd0; #1;
      checks++; if (mem_if.proc2mem_command !== BUS_STORE || mem_if.proc2mem_addr !== 32'h20 || mem_if.proc2mem_data !== 32'h55) begin
        errors++; $display("FAIL st_bus_t%0d got %0d/%h/%h exp 2/20/55", k, mem_if.proc2mem_command, mem_if.proc2mem_addr, mem_if.proc2mem_data); end
      checks++; if (st_done !== (k == 3)) begin errors++; $display("FAIL st_done_t%0d got %0b exp %0b", k, st_done, (k == 3)); end
    end
    @(negedge clock); st_req = 1'b0; mem_if.mem2proc_response = '0; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE || mem_busy !== 1'b0 || st_done !== 1'b0) begin
      errors++; $display("FAIL st_after cmd/busy/done got %0d/%0b/%0b exp 0/0/0", mem_if.proc2mem_command, mem_busy, st_done); end
  endtask

  task automatic test_contention();
    @(negedge clock); st_req = 1'b1; st_addr = 32'h30; st_data = 32'hAA; st_size = 2'd0;
    read_mem = 1'b1; load_address = 32'h40; load_rob_tag = 5'd7; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %0b exp 1", mem_busy); end
    @(negedge clock); read_mem = 1'b0; mem_if.mem2proc_response = 4'd2; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_STORE || mem_if.proc2mem_addr !== 32'h30 || st_done !== 1'b1) begin
      errors++; $display("FAIL cont_store got %0d/%h/%0b exp 2/30/1", mem_if.proc2mem_command, mem_if.proc2mem_addr, st_done); end
    @(negedge clock); st_req = 1'b0; mem_if.mem2proc_response = '0; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE || mem_busy !== 1'b0) begin
      errors++; $display("FAIL cont_after got %0d/%0b exp 0/0", mem_if.proc2mem_command, mem_busy); end
    @(negedge clock); #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE || ld_done_valid !== 1'b0) begin
      errors++; $display("FAIL cont_load_ignored got %0d/%0b exp 0/0", mem_if.proc2mem_command, ld_done_valid); end
  endtask

  task automatic test_flush();
    // Flush while waiting: drain until tag 5 returns, no result.
    @(negedge clock); read_mem = 1'b1; load_address = 32'h44; load_rob_tag = 5'd3;
    @(negedge clock); read_mem = 1'b0; mem_if.mem2proc_response = 4'd5;
    @(negedge clock); mem_if.mem2proc_response = '0; flush = 1'b1; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL fw_busy0 got %0b exp 1", mem_busy); end
    @(negedge clock); flush = 1'b0; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL fw_busy1 got %0b exp 1", mem_busy); end
    @(negedge clock); mem_if.mem2proc_tag = 4'd5; mem_if.mem2proc_data = 32'h1234; #1;
    checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL fw_busy2 got %0b exp 1", mem_busy); end
    @(negedge clock); mem_if.mem2proc_tag = '0; #1;
    checks++; if (ld_done_valid !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL fw_end valid/busy got %0b/%0b exp 0/0", ld_done_valid, mem_busy); end
    // Flush during issue beats acceptance and hides the command.
    @(negedge clock); read_mem = 1'b1; load_address = 32'h48; load_rob_tag = 5'd4;
    @(negedge clock); read_mem = 1'b0; flush = 1'b1; mem_if.mem2proc_response = 4'd6; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL fi_cmd got %0d exp 0", mem_if.proc2mem_command); end
    @(negedge clock); flush = 1'b0; mem_if.mem2proc_response = '0; mem_if.mem2proc_tag = 4'd6; #1;
    checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL fi_busy got %0b exp 0", mem_busy); end
    @(negedge clock); mem_if.mem2proc_tag = '0; #1;
    checks++; if (ld_done_valid !== 1'b0) begin errors++; $display("FAIL fi_stale_valid got %0b exp 0", ld_done_valid); end
    // Flush in the same cycle as the matching tag.
    @(negedge clock); read_mem = 1'b1; load_address = 32'h4C; load_rob_tag = 5'd9;
    @(negedge clock); read_mem = 1'b0; mem_if.mem2proc_response = 4'd7;
    @(negedge clock); mem_if.mem2proc_response = '0; mem_if.mem2proc_tag = 4'd7; flush = 1'b1;
    @(negedge clock); mem_if.mem2proc_tag = '0; flush = 1'b0; #1;
    checks++; if (ld_done_valid !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL fm valid/busy got %0b/%0b exp 0/0", ld_done_valid, mem_busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clock); read_mem = 1'b1; load_address = 32'h50; load_rob_tag = 5'd1;
    @(negedge clock); read_mem = 1'b0; mem_if.mem2proc_response = 4'd9;
    @(negedge clock); mem_if.mem2proc_response = '0; #3; reset = 1'b0; #1;
    checks++; if (mem_if.proc2mem_command !== BUS_NONE || mem_busy !== 1'b0 || ld_done_valid !== 1'b0) begin
      errors++; $display("FAIL ar_wait cmd/busy/valid got %0d/%0b/%0b exp 0/0/0", mem_if.proc2mem_command, mem_busy, ld_done_valid); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); mem_if.mem2proc_tag = 4'd9; mem_if.mem2proc_data = 32'hBEEF;
    @(negedge clock); mem_if.mem2proc_tag = '0; #1;
    checks++; if (ld_done_valid !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL ar_stale valid/busy got %0b/%0b exp 0/0", ld_done_valid, mem_busy); end
    // Reset while a result is being presented clears it at once.
    @(negedge clock); read_mem = 1'b1; load_address = 32'h54; load_rob_tag = 5'd6;
    @(negedge clock); read_mem = 1'b0; mem_if.mem2proc_response = 4'd10;
    @(negedge clock); mem_if.mem2proc_response = '0; mem_if.mem2proc_tag = 4'd10; mem_if.mem2proc_data = 32'hCAFE;
    @(negedge clock); mem_if.mem2proc_tag = '0; #1;
    checks++; if (ld_done_valid !== 1'b1 || ld_done_data !== 32'hCAFE) begin
      errors++; $display("FAIL ar_pre valid/data got %0b/%h exp 1/cafe", ld_done_valid, ld_done_data); end
    #2; reset = 1'b0; #1;
    checks++; if (ld_done_valid !== 1'b0 || ld_done_data !== '0) begin
      errors++; $display("FAIL ar_clear valid/data got %0b/%h exp 0/0", ld_done_valid, ld_done_data); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int unsigned kind, stalls, fmode, lat, fcyc;
      logic [XLEN-1:0] a, d, exp_data;
      logic [1:0] sz;
      logic [ROB_TAG_LEN-1:0] r;
      logic [MEM_TAG_W-1:0] mt, other;
      kind = $urandom_range(0, 2);
      stalls = $urandom_range(0, 3);
      a = $urandom; d = $urandom;
      if (kind == 0) begin
        sz = 2'($urandom_range(0, 3));
        @(negedge clock); st_req = 1'b1; st_addr = a; st_data = d; st_size = sz; #1;
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL rs_busy it%0d got %0b exp 1", it, mem_busy); end
        for (int s = 0; s <= int'(stalls); s++) begin
          @(negedge clock);
          mem_if.mem2proc_response = (s == int'(stalls)) ? 4'($urandom_range(1, 15)) : 4'd0;
          flush = 1'($urandom_range(0, 1));
          read_mem = 1'($urandom_range(0, 1)); load_address = $urandom;
          #1;
          checks++; if (mem_if.proc2mem_command !== BUS_STORE || mem_if.proc2mem_addr !== a || mem_if.proc2mem_data !== d || mem_if.proc2mem_size !== sz) begin
            errors++; $display("FAIL rs_bus it%0d got %0d/%h/%h/%0d exp 2/%h/%h/%0d", it, mem_if.proc2mem_command, mem_if.proc2mem_addr, mem_if.proc2mem_data, mem_if.proc2mem_size, a, d, sz); end
          checks++; if (st_done !== (s == int'(stalls))) begin errors++; $display("FAIL rs_done it%0d got %0b exp %0b", it, st_done, (s == int'(stalls))); end
        end
        @(negedge clock); st_req = 1'b0; mem_if.mem2proc_response = '0; flush = 1'b0; read_mem = 1'b0; #1;
        checks++; if (mem_if.proc2mem_command !== BUS_NONE || mem_busy !== 1'b0) begin
          errors++; $display("FAIL rs_end it%0d got %0d/%0b exp 0/0", it, mem_if.proc2mem_command, mem_busy); end
      end else begin
        r = 5'($urandom_range(0, 31));
        fmode = $urandom_range(0, 3);
        mt = 4'($urandom_range(1, 15));
        other = 4'((mt % 15) + 1);
        exp_data = '0;
        @(negedge clock); read_mem = 1'b1; load_address = a; load_rob_tag = r; #1;
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rl_busy0 it%0d got %0b exp 0", it, mem_busy); end
        for (int s = 0; s <= int'(stalls); s++) begin
          @(negedge clock); read_mem = 1'b0;
          if (fmode == 0 && s == int'(stalls)) begin
            flush = 1'b1; mem_if.mem2proc_response = 4'($urandom_range(0, 15));
          end else begin
            mem_if.mem2proc_response = (s == int'(stalls)) ? mt : 4'd0;
          end
          #1;
          if (flush) begin
            checks++; if (mem_if.proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL rl_fcmd it%0d got %0d exp 0", it, mem_if.proc2mem_command); end
          end else begin
            checks++; if (mem_if.proc2mem_command !== BUS_LOAD || mem_if.proc2mem_addr !== a || mem_if.proc2mem_size !== WORD) begin
              errors++; $display("FAIL rl_bus it%0d got %0d/%h/%0d exp 1/%h/2", it, mem_if.proc2mem_command, mem_if.proc2mem_addr, mem_if.proc2mem_size, a); end
          end
        end
        if (fmode == 0) begin
          @(negedge clock); flush = 1'b0; mem_if.mem2proc_response = '0; #1;
          checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rl_fi_busy it%0d got %0b exp 0", it, mem_busy); end
        end else begin
          lat = $urandom_range(1, 4);
          fcyc = $urandom_range(0, lat - 1);
          for (int w = 0; w <= int'(lat); w++) begin
            @(negedge clock); mem_if.mem2proc_response = '0;
            flush = (fmode == 1 && w == int'(fcyc)) || (fmode == 2 && w == int'(lat));
            mem_if.mem2proc_tag = (w == int'(lat)) ? mt : ($urandom_range(0, 1) ? other : 4'd0);
            mem_if.mem2proc_data = $urandom;
            if (w == int'(lat)) exp_data = mem_if.mem2proc_data;
            #1;
            checks++; if (mem_busy !== 1'b1 || mem_if.proc2mem_command !== BUS_NONE) begin
              errors++; $display("FAIL rl_wait it%0d w%0d got %0b/%0d exp 1/0", it, w, mem_busy, mem_if.proc2mem_command); end
          end
          @(negedge clock); flush = 1'b0; mem_if.mem2proc_tag = '0; #1;
          checks++; if (ld_done_valid !== (fmode == 3)) begin errors++; $display("FAIL rl_valid it%0d got %0b exp %0b", it, ld_done_valid, (fmode == 3)); end
          if (fmode == 3) begin
            checks++; if (ld_done_data !== exp_data || ld_done_rob_tag !== r) begin
              errors++; $display("FAIL rl_result it%0d got %h/%0d exp %h/%0d", it, ld_done_data, ld_done_rob_tag, exp_data, r); end
          end
          checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL rl_end_busy it%0d got %0b exp 0", it, mem_busy); end
        end
      end
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    test_reset();
    checks++; if (perf_loads !== 0 || perf_stores !== 0 || perf_stall_cycles !== 0) begin
      errors++; $display("FAIL perf_reset got %0d/%0d/%0d exp 0/0/0", perf_loads, perf_stores, perf_stall_cycles); end
    test_load_basic();
    test_store_retry();
    checks++; if (perf_loads !== 32'd1) begin errors++; $display("FAIL perf_loads got %0d exp 1", perf_loads); end
    checks++; if (perf_stores !== 32'd1) begin errors++; $display("FAIL perf_stores got %0d exp 1", perf_stores); end
    checks++; if (perf_stall_cycles !== 32'd2) begin errors++; $display("FAIL perf_stalls got %0d exp 2", perf_stall_cycles); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_basic();
    test_store_retry();
    test_contention();
    test_flush();
    test_async_reset();
    idle_inputs();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single data-memory port between the load buffer (one speculative load at a time) and the ROB store-commit path. Committed stores always take priority. The block tracks one outstanding memory transaction and returns load data with its ROB tag for CDB broadcast. It drives `mem_busy` back to the load buffer and drains in-flight loads on a pipeline flush.

Parameters:
- `XLEN`, 32, address/data width (from `sys_defs`).
- `ROB_TAG_LEN`, 5, ROB tag width (from `sys_defs`).
- `MEM_TAG_W`, 4, memory transaction tag width; tag 0 means "not accepted".

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `read_mem`  in  1  load buffer load request; legal only while `mem_busy`=0.
- `load_address`  in  XLEN  load address.
- `load_rob_tag`  in  ROB_TAG_LEN  load ROB tag.
- `st_req`  in  1  ROB head store ready to commit; held until `st_done`.
- `st_addr`  in  XLEN  store address.
- `st_data`  in  XLEN  store data.
- `st_size`  in  2  `MEM_SIZE` of the store.
- `flush`  in  1  ROB squash; kills any non-store transaction.
- `mem2proc_response`  in  MEM_TAG_W  nonzero = command accepted with this tag.
- `mem2proc_data`  in  XLEN  returned load data.
- `mem2proc_tag`  in  MEM_TAG_W  tag of returned data; 0 = none.
- `proc2mem_command`  out  2  `BUS_NONE`/`BUS_LOAD`/`BUS_STORE`.
- `proc2mem_addr`  out  XLEN  memory address.
- `proc2mem_data`  out  XLEN  store data.
- `proc2mem_size`  out  2  access size (`WORD` for loads).
- `mem_busy`  out  1  to load buffer: a load presented now would not be accepted.
- `st_done`  out  1  to ROB: store accepted by memory this cycle.
- `ld_done_valid`  out  1  load result valid (registered).
- `ld_done_data`  out  XLEN  load result.
- `ld_done_rob_tag`  out  ROB_TAG_LEN  ROB tag of the result.

Behaviour:
- Reset:
  - State `IDLE`.
  - All latched fields and registered outputs cleared to 0.
  - `proc2mem_command`=`BUS_NONE`.
  - Reset mid-transaction abandons the transaction silently.
- States and transitions:
  - `IDLE`: if `st_req`, latch the store and go to `ST_ISSUE`. Else if `read_mem`, latch address/tag and go to `LD_ISSUE`. Stores win any same-cycle contention.
  - `ST_ISSUE`: drive `BUS_STORE` with latched addr/data/size. On `mem2proc_response`!=0, `st_done`=1 combinationally in that cycle and go to `IDLE`. On response 0, hold the command and retry.
  - `LD_ISSUE`: drive `BUS_LOAD`, size `WORD`. On response!=0, save the tag and go to `LD_WAIT`. On response 0, retry. If `flush`=1, go to `IDLE` with the command suppressed that cycle; flush wins over acceptance.
  - `LD_WAIT`: drive `BUS_NONE`. When `mem2proc_tag`==saved tag and is nonzero, register data and ROB tag, set `ld_done_valid`=1 for exactly one cycle, and go to `IDLE`. If `flush`=1, go to `LD_DRAIN`.
  - `LD_DRAIN`: drive `BUS_NONE`. Wait for the matching tag, then go to `IDLE` with no `ld_done_valid`. A flush arriving in the same cycle as the matching tag suppresses `ld_done_valid`.
- `flush` in `IDLE`/`ST_ISSUE` has no effect; stores are committed and never squashed.
- `mem_busy` = (state!=`IDLE`) || `st_req`. It never depends combinationally on `read_mem`.
- Latency, `read_mem` at cycle t: `BUS_LOAD` at t+1. With acceptance at t+1 and data at t+k, `ld_done_valid` is at t+k+1 and `mem_busy`=0 at t+k+1.
- Only one transaction is outstanding. `proc2mem_*` values are don't-care (driven 0) when the command is `BUS_NONE`.
- `read_mem` while `mem_busy`=1 is a protocol error and is ignored.

Optional Feature:
- Macro: `MEM_ARB_PERF_EN`.
- When defined, adds three 32-bit outputs:
  - `perf_loads`: accepted loads.
  - `perf_stores`: accepted stores.
  - `perf_stall_cycles`: cycles in an `*_ISSUE` state with response 0.
- The counters reset to 0 and saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- `sys_defs` package holds: `ARB_STATE` enum (`IDLE`, `ST_ISSUE`, `LD_ISSUE`, `LD_WAIT`, `LD_DRAIN`); `MEM_TAG_W`; and an `ARB_LD_PACKET` struct {address, rob_tag, mem_tag}. `BUS_*` and `MEM_SIZE` are reused.
- One natural sub-module: `mem_arb_perf_counters`, instantiated only under `MEM_ARB_PERF_EN`.

Test Plan:
1. Load with response 3 at t+1 and tag 3 at t+4: `read_mem`=1, addr 0x10, rob 2 at t. Expect `BUS_LOAD` addr 0x10 at t+1, `mem_busy`=1 for t+1..t+4, then `ld_done_valid`=1, data 0xDEAD, rob 2 at t+5.
2. `st_req`=1 (addr 0x20, data 0x55) with response 0 for 2 cycles, then 1. Expect `BUS_STORE` held 3 cycles and `st_done` only in the third.
3. `st_req` and `read_mem` both high in `IDLE`. Expect the store issued first; the load is ignored, and `mem_busy`=1 shows the request was illegal.
4. `flush` in `LD_WAIT`, then tag returns 2 cycles later. Expect no `ld_done_valid`, `mem_busy`=1 until the tag returns, then `IDLE`.
5. Async reset (`reset`=0) asserted mid-`LD_WAIT`. Expect `BUS_NONE`, `mem_busy`=0, and `ld_done_valid`=0 immediately; a stale tag after release is ignored.
6. Under `MEM_ARB_PERF_EN`, run scenarios 1 and 2. Expect `perf_loads`=1, `perf_stores`=1, `perf_stall_cycles`=2.
